hfg_nwayrec: RTL and testbench

HFG_NWAYREC -- requirements
Module: hfg_nwayrec

---
 rtl/hfg_pkg.sv | 21 ++
 rtl/hfg_nwayrec_if.sv | 31 +++
 rtl/hfg_rec_stage.sv | 28 ++
 rtl/hfg_nwayrec.sv | 138 +++++++++++++
 tb/tb_hfg_nwayrec.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hfg_pkg.sv
// Shared constants and width helpers for the hfg_nwayrec rectangle-feature pipeline.
package hfg_pkg;

    localparam int DATA_W_DEF  = 21;
    localparam int NUM_CORNERS = 4;

    // Corner slot order inside one channel of i4Rec, A in the LSBs.
    localparam int CORNER_A = 0;
    localparam int CORNER_B = 1;
    localparam int CORNER_C = 2;
    localparam int CORNER_D = 3;

    function automatic int rec_w(input int data_w);
        return data_w + 2;
    endfunction

    function automatic int feat_w(input int data_w, input int weight_w, input int num_rec);
        return rec_w(data_w) + weight_w + $clog2(num_rec);
    endfunction

endpackage

// File: rtl/hfg_nwayrec_if.sv
// Handshake bundle for hfg_nwayrec: the input beat (valid/ready plus channel data)
// and the result beat (valid/ready plus rectangle sums and feature).
interface hfg_nwayrec_if #(
    parameter int NUM_REC  = 8,
    parameter int DATA_W   = hfg_pkg::DATA_W_DEF,
    parameter int WEIGHT_W = 4
);
    localparam int REC_W  = hfg_pkg::rec_w(DATA_W);
    localparam int FEAT_W = hfg_pkg::feat_w(DATA_W, WEIGHT_W, NUM_REC);

    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_REC-1:0]              sign;
    logic [NUM_REC*4*DATA_W-1:0]     rec4;
    logic [NUM_REC*WEIGHT_W-1:0]     weight;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_REC*REC_W-1:0]        rec;
    logic [FEAT_W-1:0]               feature;

    modport master (
        output in_valid, sign, rec4, weight, out_ready,
        input  in_ready, out_valid, rec, feature
    );

    modport slave (
        input  in_valid, sign, rec4, weight, out_ready,
        output in_ready, out_valid, rec, feature
    );

endinterface

// File: rtl/hfg_rec_stage.sv
// One rectangle channel: r = A + D - B - C over four integral-image corners,
// negated when the channel sign flag is set. Purely combinational.
module hfg_rec_stage import hfg_pkg::*; #(
    parameter  int DATA_W = DATA_W_DEF,
    localparam int REC_W  = rec_w(DATA_W)
) (
    input  logic [NUM_CORNERS*DATA_W-1:0] corners_i,
    input  logic                          sign_i,
    output logic signed [REC_W-1:0]       rec_o
);

    logic signed [REC_W-1:0] a_ext;
    logic signed [REC_W-1:0] b_ext;
    logic signed [REC_W-1:0] c_ext;
    logic signed [REC_W-1:0] d_ext;
    logic signed [REC_W-1:0] sum;

    // Two guard bits cover both the carry of A+D and the borrow of -B-C.
    always_comb begin
        a_ext = $signed({2'b00, corners_i[CORNER_A*DATA_W +: DATA_W]});
        b_ext = $signed({2'b00, corners_i[CORNER_B*DATA_W +: DATA_W]});
        c_ext = $signed({2'b00, corners_i[CORNER_C*DATA_W +: DATA_W]});
        d_ext = $signed({2'b00, corners_i[CORNER_D*DATA_W +: DATA_W]});
        sum   = a_ext + d_ext - b_ext - c_ext;
        rec_o = sign_i ? -sum : sum;
    end

endmodule

// File: rtl/hfg_nwayrec.sv
// N-way rectangle feature pipeline: S1 input register, S2 per-channel rectangles,
// S3 weighted feature sum. The feature sum is built only with HFG_FEATURE_SUM_EN.
module hfg_nwayrec import hfg_pkg::*; #(
    parameter  int NUM_REC  = 8,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int WEIGHT_W = 4,
    localparam int REC_W    = rec_w(DATA_W),
    localparam int FEAT_W   = feat_w(DATA_W, WEIGHT_W, NUM_REC)
) (
    input  logic                               iClk,
    input  logic                               iReset,
    input  logic                               iValid,
    output logic                               oReady,
    input  logic [NUM_REC-1:0]                 iSign,
    input  logic [NUM_REC*NUM_CORNERS*DATA_W-1:0] i4Rec,
    input  logic [NUM_REC*WEIGHT_W-1:0]        iWeight,
    output logic                               oValid,
    input  logic                               iReady,
    output logic [NUM_REC*REC_W-1:0]           oRec,
    output logic [FEAT_W-1:0]                  oFeature
);

    localparam int CORN_W = NUM_CORNERS * DATA_W;

    logic                         advance;

    logic                         vld_p0_q;
    logic [NUM_REC-1:0]           sign_p0_q;
    logic [NUM_REC*CORN_W-1:0]    corners_p0_q;

    logic                         vld_p1_q;
    logic signed [REC_W-1:0]      rec_p1_d [NUM_REC];
    logic signed [REC_W-1:0]      rec_p1_q [NUM_REC];

    logic                         vld_p2_q;
    logic signed [REC_W-1:0]      rec_p2_q [NUM_REC];

    // Whole pipe moves as one; it freezes only while a result waits on downstream.
    assign advance = !(vld_p2_q && !iReady);
    assign oReady  = advance;
    assign oValid  = vld_p2_q;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else if (advance) begin
            vld_p0_q <= iValid;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            sign_p0_q    <= '0;
            corners_p0_q <= '0;
            for (int i = 0; i < NUM_REC; i++) begin
                rec_p1_q[i] <= '0;
                rec_p2_q[i] <= '0;
            end
        end else if (advance) begin
            if (iValid) begin
                sign_p0_q    <= iSign;
                corners_p0_q <= i4Rec;
            end
            if (vld_p0_q) begin
                rec_p1_q <= rec_p1_d;
            end
            if (vld_p1_q) begin
                rec_p2_q <= rec_p1_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_REC; g++) begin : g_ch
        hfg_rec_stage #(
            .DATA_W (DATA_W)
        ) u_rec (
            .corners_i (corners_p0_q[g*CORN_W +: CORN_W]),
            .sign_i    (sign_p0_q[g]),
            .rec_o     (rec_p1_d[g])
        );
        assign oRec[g*REC_W +: REC_W] = rec_p2_q[g];
    end

`ifdef HFG_FEATURE_SUM_EN
    logic [NUM_REC*WEIGHT_W-1:0]  wgt_p0_q;
    logic [NUM_REC*WEIGHT_W-1:0]  wgt_p1_q;
    logic signed [FEAT_W-1:0]     feat_p2_d;
    logic signed [FEAT_W-1:0]     feat_p2_q;

    // Product is formed at full feature width so the accumulation can never wrap.
    function automatic logic signed [FEAT_W-1:0] weighted(
        input logic signed [REC_W-1:0] r,
        input logic [WEIGHT_W-1:0]     w
    );
        logic signed [FEAT_W-1:0] r_ext;
        logic signed [FEAT_W-1:0] w_ext;
        r_ext = {{(FEAT_W-REC_W){r[REC_W-1]}}, r};
        w_ext = {{(FEAT_W-WEIGHT_W){1'b0}}, w};
        return r_ext * w_ext;
    endfunction

    always_comb begin
        feat_p2_d = '0;
        for (int i = 0; i < NUM_REC; i++) begin
            feat_p2_d = feat_p2_d + weighted(rec_p1_q[i], wgt_p1_q[i*WEIGHT_W +: WEIGHT_W]);
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            wgt_p0_q  <= '0;
            wgt_p1_q  <= '0;
            feat_p2_q <= '0;
        end else if (advance) begin
            if (iValid) begin
                wgt_p0_q <= iWeight;
            end
            if (vld_p0_q) begin
                wgt_p1_q <= wgt_p0_q;
            end
            if (vld_p1_q) begin
                feat_p2_q <= feat_p2_d;
            end
        end
    end

    assign oFeature = feat_p2_q;
`else
    logic unused_weight;
    assign unused_weight = ^iWeight;
    assign oFeature      = '0;
`endif

endmodule

// File: tb/tb_hfg_nwayrec.sv
// Bench for hfg_nwayrec: directed literal cases plus randomized traffic checked every
// cycle against a queue-based arithmetic model. Honors HFG_FEATURE_SUM_EN.
module tb_hfg_nwayrec;
    import hfg_pkg::*;

    localparam int NUM_REC  = 8;
    localparam int DATA_W   = 21;
    localparam int WEIGHT_W = 4;
    localparam int REC_W    = rec_w(DATA_W);
    localparam int FEAT_W   = feat_w(DATA_W, WEIGHT_W, NUM_REC);
    localparam int IN_W     = NUM_REC * 4 * DATA_W;
    localparam int WT_W     = NUM_REC * WEIGHT_W;
    localparam int RV_W     = NUM_REC * REC_W;
`ifdef HFG_FEATURE_SUM_EN
    localparam bit FEAT_EN  = 1'b1;
`else
    localparam bit FEAT_EN  = 1'b0;
`endif
    localparam longint MAXC = (64'sd1 <<< DATA_W) - 1;

    typedef struct packed {
        logic signed [NUM_REC-1:0][63:0] rec;
        logic signed [63:0]              feat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   n_out  = 0;
    exp_t q[$];

    hfg_nwayrec_if #(.NUM_REC(NUM_REC), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) bus ();

    hfg_nwayrec #(.NUM_REC(NUM_REC), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) dut (
        .iClk     (clk),
        .iReset   (rst),
        .iValid   (bus.in_valid),
        .oReady   (bus.in_ready),
        .iSign    (bus.sign),
        .i4Rec    (bus.rec4),
        .iWeight  (bus.weight),
        .oValid   (bus.out_valid),
        .iReady   (bus.out_ready),
        .oRec     (bus.rec),
        .oFeature (bus.feature)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic longint corner(input logic [IN_W-1:0] c4, input int ch, input int k);
        longint v;
        v = 0;
        v[DATA_W-1:0] = c4[(4*ch+k)*DATA_W +: DATA_W];
        return v;
    endfunction

    // Reference: plain integer arithmetic on the rectangle and feature definitions.
    function automatic exp_t model(input logic [NUM_REC-1:0] sg, input logic [IN_W-1:0] c4,
                                   input logic [WT_W-1:0] w);
        exp_t   e;
        longint r;
        longint wv;
        longint f;
        e = '0;
        f = 0;
        for (int i = 0; i < NUM_REC; i++) begin
            r = corner(c4, i, 0) + corner(c4, i, 3) - corner(c4, i, 1) - corner(c4, i, 2);
            if (sg[i]) r = -r;
            wv = 0;
            wv[WEIGHT_W-1:0] = w[i*WEIGHT_W +: WEIGHT_W];
            e.rec[i] = r;
            f = f + r * wv;
        end
        e.feat = FEAT_EN ? f : 64'sd0;
        return e;
    endfunction

    function automatic logic signed [63:0] act_rec(input int i);
        logic signed [REC_W-1:0] s;
        s = bus.rec[i*REC_W +: REC_W];
        return s;
    endfunction

    function automatic logic signed [63:0] act_feat();
        logic signed [FEAT_W-1:0] s;
        s = bus.feature;
        return s;
    endfunction

    function automatic logic [IN_W-1:0] put(input logic [IN_W-1:0] v, input int ch, input int k,
                                            input longint val);
        v[(4*ch+k)*DATA_W +: DATA_W] = val[DATA_W-1:0];
        return v;
    endfunction

    function automatic logic [WT_W-1:0] putw(input logic [WT_W-1:0] v, input int ch, input int val);
        v[ch*WEIGHT_W +: WEIGHT_W] = val[WEIGHT_W-1:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [RV_W-1:0] act, input logic [RV_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic rand_beat(output logic [NUM_REC-1:0] sg, output logic [IN_W-1:0] c4,
                             output logic [WT_W-1:0] w);
        longint v;
        sg = NUM_REC'($urandom());
        w  = WT_W'({$urandom(), $urandom()});
        c4 = '0;
        for (int i = 0; i < NUM_REC * 4; i++) begin
            case ($urandom_range(0, 7))
                0:       v = MAXC;
                1:       v = 0;
                default: v = longint'($urandom()) & MAXC;
            endcase
            c4 = put(c4, i / 4, i % 4, v);
        end
    endtask

    // Every cycle: handshake rule, hold under stall, and ordered results vs. the model.
    initial begin : compare
        logic              stall_prev;
        logic [RV_W-1:0]   rec_prev;
        logic signed [63:0] feat_prev;
        stall_prev = 1'b0;
        rec_prev   = '0;
        feat_prev  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                stall_prev = 1'b0;
            end else begin
                chk("oReady_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
                if (stall_prev) begin
                    chk_wide("hold_oRec", bus.rec, rec_prev);
                    chk("hold_oFeature", act_feat(), feat_prev);
                end
                if (bus.out_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_output: got oValid=1, required no pending result");
                    end else begin
                        for (int i = 0; i < NUM_REC; i++)
                            chk($sformatf("oRec%0d", i), act_rec(i), q[0].rec[i]);
                        chk("oFeature", act_feat(), q[0].feat);
                        if (bus.out_ready) begin
                            void'(q.pop_front());
                            n_out++;
                        end
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                rec_prev   = bus.rec;
                feat_prev  = act_feat();
                if (bus.in_valid && bus.in_ready)
                    q.push_back(model(bus.sign, bus.rec4, bus.weight));
            end
        end
    end

    // Called at #1 after a rising edge with the pipe able to accept.
    task automatic send_single(input logic [NUM_REC-1:0] sg, input logic [IN_W-1:0] c4,
                               input logic [WT_W-1:0] w, output int lat,
                               output logic signed [63:0] r0, output logic signed [63:0] r1,
                               output logic signed [63:0] ft);
        bus.sign     = sg;
        bus.rec4     = c4;
        bus.weight   = w;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r0 = act_rec(0);
        r1 = act_rec(1);
        ft = act_feat();
        @(posedge clk);
        #1;
        chk("single_oValid_drop", bus.out_valid, 0);
    endtask

    initial begin : stim
        logic [NUM_REC-1:0] sg;
        logic [IN_W-1:0]    c4;
        logic [WT_W-1:0]    w;
        logic [NUM_REC-1:0] bsg [10];
        logic [IN_W-1:0]    bc4 [10];
        logic [WT_W-1:0]    bw  [10];
        int                 lat;
        int                 sent;
        int                 base;
        logic               acc;
        logic signed [63:0] r0;
        logic signed [63:0] r1;
        logic signed [63:0] ft;

        bus.in_valid  = 1'b0;
        bus.sign      = '0;
        bus.rec4      = '0;
        bus.weight    = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_oValid", bus.out_valid, 0);
        chk("rst_oReady", bus.in_ready, 1);
        chk_wide("rst_oRec", bus.rec, '0);
        chk("rst_oFeature", act_feat(), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_oReady", bus.in_ready, 1);

        // Single beat on channel 0.
        sg = '0;
        c4 = '0;
        c4 = put(c4, 0, 0, 10);
        c4 = put(c4, 0, 1, 20);
        c4 = put(c4, 0, 2, 30);
        c4 = put(c4, 0, 3, 100);
        w  = putw('0, 0, 2);
        send_single(sg, c4, w, lat, r0, r1, ft);
        chk("single_latency", lat, 3);
        chk("single_oRec0", r0, 60);
        chk("single_oFeature", ft, FEAT_EN ? 120 : 0);

        // Sign path plus a second weighted channel.
        sg = 8'b0000_0001;
        c4 = put(c4, 1, 3, 5);
        w  = putw(w, 1, 3);
        send_single(sg, c4, w, lat, r0, r1, ft);
        chk("sign_latency", lat, 3);
        chk("sign_oRec0", r0, -60);
        chk("sign_oRec1", r1, 5);
        chk("sign_oFeature", ft, FEAT_EN ? -105 : 0);

        // Extreme corners on every channel at maximum weight.
        sg = '0;
        c4 = '0;
        w  = '0;
        for (int i = 0; i < NUM_REC; i++) begin
            c4 = put(c4, i, 0, MAXC);
            c4 = put(c4, i, 3, MAXC);
            w  = putw(w, i, 15);
        end
        send_single(sg, c4, w, lat, r0, r1, ft);
        chk("ext_oRec0", r0, 4194302);
        chk("ext_oRec1", r1, 4194302);
        chk("ext_oFeature", ft, FEAT_EN ? 64'sd503316240 : 64'sd0);

        // Ten back-to-back beats with downstream stalled for cycles 4-7.
        for (int b = 0; b < 10; b++) rand_beat(bsg[b], bc4[b], bw[b]);
        base = n_out;
        sent = 0;
        for (int c = 0; c < 60 && (sent < 10 || q.size() > 0); c++) begin
            bus.out_ready = !(c >= 4 && c <= 7);
            if (sent < 10) begin
                bus.in_valid = 1'b1;
                bus.sign     = bsg[sent];
                bus.rec4     = bc4[sent];
                bus.weight   = bw[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (c >= 4 && c <= 7) chk("bp_oReady_stall", bus.in_ready, 0);
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_sent", sent, 10);
        chk("bp_received", n_out - base, 10);

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            rand_beat(sg, c4, w);
            bus.sign      = sg;
            bus.rec4      = c4;
            bus.weight    = w;
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("rand_drain", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset with two beats in flight.
        rand_beat(sg, c4, w);
        bus.sign = sg; bus.rec4 = c4; bus.weight = w; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        rand_beat(sg, c4, w);
        bus.sign = sg; bus.rec4 = c4; bus.weight = w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_oReady", bus.in_ready, 1);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("midrst_quiet", bus.out_valid, 0);
            @(posedge clk);
            #1;
        end
        sg = '0;
        c4 = '0;
        c4 = put(c4, 0, 0, 10);
        c4 = put(c4, 0, 1, 20);
        c4 = put(c4, 0, 2, 30);
        c4 = put(c4, 0, 3, 100);
        w  = putw('0, 0, 2);
        send_single(sg, c4, w, lat, r0, r1, ft);
        chk("midrst_latency", lat, 3);
        chk("midrst_oRec0", r0, 60);
        chk("midrst_oFeature", ft, FEAT_EN ? 120 : 0);

        repeat (2) @(posedge clk);
        #1;
        chk("final_queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
